// File: rtl/posit_pack_pipe_if.sv
// Stream interface for the posit pack pipeline.
// Carries the unpacked operand (sign, signed scale, fraction, sticky, special
// flags) with its valid/ready pair, and the encoded posit result with its own
// valid/ready pair. The master drives operands and consumes results.
interface posit_pack_pipe_if #(
    parameter int N  = 16,
    parameter int es = 2
);
    localparam int Bs = $clog2(N);
    localparam int SW = es + Bs + 2;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [SW-1:0] in_scale;
    logic [N-1:0]         in_frac;
    logic                 in_sticky;
    logic                 in_zero;
    logic                 in_inf;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out;
    logic                 out_inf;
    logic                 out_zero;

    modport master (
        output in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_inf, out_ready,
        input  in_ready, out_valid, out, out_inf, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_scale, in_frac, in_sticky, in_zero, in_inf, out_ready,
        output in_ready, out_valid, out, out_inf, out_zero
    );
endinterface

// File: rtl/posit_pack_pipe.sv
// Three-stage pipelined posit encoder with valid/ready flow control.
// Stage p0 classifies the operand and splits the scale into regime count k
// and exponent e; stage p1 builds the regime and shifts {regime, e, frac}
// into the posit body with guard/round/sticky; stage p2 rounds, clamps to
// minpos/maxpos, applies the sign and resolves NaR/zero.
// Build option: define POSIT_PACK_RNE_EN for round-to-nearest-even;
// otherwise the body is truncated toward zero magnitude.
module posit_pack_pipe #(
    parameter int N  = 16,
    parameter int es = 2
) (
    input logic              clk,
    input logic              rst_n,
    posit_pack_pipe_if.slave bus
);
    localparam int Bs   = $clog2(N);
    localparam int SW   = es + Bs + 2;
    localparam int KW   = SW - es;          // regime count width
    localparam int SMAX = N - 3;            // largest regime shift for an unsaturated scale
    localparam int WW   = 2 + es + N + SMAX; // shifter width, nothing falls off the end
    localparam int BW   = N - 1;            // posit body without the sign bit

    localparam logic signed [SW:0] SAT_HI = (SW+1)'((N - 2) << es);
    localparam logic signed [SW:0] SAT_LO = -SAT_HI;
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

`ifdef POSIT_PACK_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    // Round-to-nearest-even increment; zero when truncating.
    function automatic logic round_inc(input logic l, input logic g, input logic r, input logic st);
        logic rne;
        rne = g & (r | st | l);
        return RNE_EN ? rne : 1'b0;
    endfunction

    // Forces saturated scales and out-of-range rounded magnitudes onto minpos/maxpos.
    function automatic logic [N-1:0] saturate(input logic hi, input logic lo, input logic [N-1:0] sum);
        if (hi || sum[N-1]) return MAXPOS;
        if (lo || (sum == '0)) return MINPOS;
        return sum;
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic ready_p0, ready_p1, ready_p2;

    logic                 sign_p0, sticky_p0, inf_p0, zero_p0, sat_hi_p0, sat_lo_p0;
    logic signed [KW-1:0] k_p0;
    logic [es-1:0]        e_p0;
    logic [N-1:0]         frac_p0;

    logic          sign_p1, g_p1, r_p1, st_p1, inf_p1, zero_p1, sat_hi_p1, sat_lo_p1;
    logic [BW-1:0] body_p1;

    logic [N-1:0] out_p2;
    logic         out_inf_p2, out_zero_p2;

    logic signed [SW:0] scale_x;
    logic               sat_hi, sat_lo;
    logic               fill;
    logic [KW-1:0]      shamt;
    logic [WW-1:0]      wide, shifted;
    logic               inc;
    logic [N-1:0]       mag_sum, mag, posit;

    assign ready_p2 = !vld_p2 || bus.out_ready;
    assign ready_p1 = !vld_p1 || ready_p2;
    assign ready_p0 = !vld_p0 || ready_p1;

    assign bus.in_ready  = ready_p0;
    assign bus.out_valid = vld_p2;
    assign bus.out       = out_p2;
    assign bus.out_inf   = out_inf_p2;
    assign bus.out_zero  = out_zero_p2;

    // Saturation compare on a sign-extended scale so the extremes cannot wrap.
    always_comb begin
        scale_x = {bus.in_scale[SW-1], bus.in_scale};
        sat_hi  = scale_x >= SAT_HI;
        sat_lo  = scale_x < SAT_LO;
    end

    // Regime builder: shift {10|01, e, frac} right by k (or ~k), filling with the regime bit.
    always_comb begin
        fill    = ~k_p0[KW-1];
        shamt   = k_p0[KW-1] ? ~k_p0 : k_p0;
        wide    = {fill, ~fill, e_p0, frac_p0, {SMAX{1'b0}}};
        shifted = fill ? ~((~wide) >> shamt) : (wide >> shamt);
    end

    // Round, clamp, apply sign, then let NaR and zero override everything.
    always_comb begin
        inc     = round_inc(body_p1[0], g_p1, r_p1, st_p1);
        mag_sum = {1'b0, body_p1} + {{(N-1){1'b0}}, inc};
        mag     = saturate(sat_hi_p1, sat_lo_p1, mag_sum);
        posit   = sign_p1 ? -mag : mag;
        if (inf_p1) posit = NAR;
        else if (zero_p1) posit = '0;
    end

    // Stage valid bits and the registered result; a stage advances when it is empty or its successor takes its item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_p2      <= '0;
            out_inf_p2  <= 1'b0;
            out_zero_p2 <= 1'b0;
        end else begin
            if (ready_p0) vld_p0 <= bus.in_valid;
            if (ready_p1) vld_p1 <= vld_p0;
            if (ready_p2) vld_p2 <= vld_p1;
            // ---- stage p2: rounded posit ----
            if (ready_p2 && vld_p1) begin
                out_p2      <= posit;
                out_inf_p2  <= inf_p1;
                out_zero_p2 <= zero_p1 && !inf_p1;
            end
        end
    end

    // Datapath registers for stages p0 and p1; no reset, qualified by the valid bits.
    always_ff @(posedge clk) begin
        // ---- stage p0: classify and split scale; k is the arithmetic floor scale >>> es ----
        if (ready_p0 && bus.in_valid) begin
            sign_p0   <= bus.in_sign;
            k_p0      <= bus.in_scale[SW-1:es];
            e_p0      <= bus.in_scale[es-1:0];
            frac_p0   <= bus.in_frac;
            sticky_p0 <= bus.in_sticky;
            inf_p0    <= bus.in_inf;
            zero_p0   <= bus.in_zero && !bus.in_inf;
            sat_hi_p0 <= sat_hi && !bus.in_inf && !bus.in_zero;
            sat_lo_p0 <= sat_lo && !bus.in_inf && !bus.in_zero;
        end
        // ---- stage p1: regime-built body with guard, round and sticky ----
        if (ready_p1 && vld_p0) begin
            sign_p1   <= sign_p0;
            body_p1   <= shifted[WW-1 -: BW];
            g_p1      <= shifted[WW-1-BW];
            r_p1      <= shifted[WW-2-BW];
            st_p1     <= (|shifted[WW-3-BW:0]) | sticky_p0;
            inf_p1    <= inf_p0;
            zero_p1   <= zero_p0;
            sat_hi_p1 <= sat_hi_p0;
            sat_lo_p1 <= sat_lo_p0;
        end
    end
endmodule
